adj_level_ctrl: RTL and testbench
=================================

// Module: adj_level_ctrl
// PURPOSE
//  Turns the single-cycle brightness/contrast/saturation inc/dec pulses from the
//  control decoder into held, clamped level registers for the colour datapath.
//  Edits land in shadow registers at once; shadow->active copy happens only at a
//  frame boundary (vsync rising edge), so the datapath never changes mid-frame.
//  Sits between the control decoder and the brightness/contrast/saturation stage.
// PARAMETERS
//  BR_STEP  8    brightness step, signed offset units
//  BR_LIM   96   brightness clamp magnitude; range [-BR_LIM,+BR_LIM]
//  CT_STEP  8    contrast step (gain Q1.7, 128 = x1.0)
//  CT_MIN   32   contrast lower clamp; upper clamp 255
//  SAT_STEP 16   saturation step (Q1.7); range [0,255]
// PORTS
//  clk      in   1  pixel-domain clock
//  rst      in   1  asynchronous, active-low reset
//  binc     in   1  brightness +1 step pulse
//  bdec     in   1  brightness -1 step pulse
//  cinc     in   1  contrast +1 step pulse
//  cdec     in   1  contrast -1 step pulse
//  sinc     in   1  saturation +1 step pulse
//  sdec     in   1  saturation -1 step pulse
//  def_load in   1  pulse: load all shadow levels with defaults
//  vsync    in   1  frame sync, active-high, synchronous to clk
//  bright   out  8  active brightness, signed two's complement
//  contr    out  8  active contrast gain, unsigned Q1.7
//  satur    out  8  active saturation gain, unsigned Q1.7
//  dirty    out  1  shadow differs from active (commit pending)
//  upd      out  1  one-cycle pulse: active levels changed this cycle
// BEHAVIOUR
//  Reset (rst=0, async): shadow+active bright=0, contr=128, satur=128; dirty=0,
//   upd=0, vs_q=0, FSM=IDLE.
//  Step: pulse sampled at cycle N -> shadow updated at N+1. Compute in 10-bit
//   signed, then clamp to channel range; at a limit the value holds, no wrap.
//  inc and dec on the same channel, same cycle -> channel unchanged.
//   Different channels in the same cycle -> all apply independently.
//  def_load has priority over every step pulse in the same cycle.
//  dirty is set only when a step or def_load changes a shadow value.
//   A clamped no-op or a default load that equals active leaves dirty unchanged.
//  Frame edge: vsync_rise = vsync & ~vs_q, with vs_q registered every cycle.
//  FSM IDLE: dirty=0. Any shadow change -> PEND.
//  FSM PEND: on vsync_rise at cycle M -> active<=shadow (the value held in M),
//   upd=1 for cycle M+1 only.
//   Then -> IDLE, or stay in PEND if a pulse in cycle M changed shadow.
//   That change is committed at the next frame.
//  vsync_rise in IDLE: no copy, upd stays 0.
//  Held vsync high: one commit per rising edge only.
//  Outputs are registered; active levels change only at reset or on a commit.
//  Reset asserted mid-frame or while PEND: pending edits are discarded and all
//   levels return to defaults.
// STRUCTURE
//  Package adj_pkg: default values, range limits, FSM state enum {IDLE,PEND}.
//  Sub-module sat_step: one registered shadow channel.
//   Inputs: inc, dec, load, step, min, max. Outputs: value, changed.
//   Instantiated 3x (brightness signed, contrast and saturation unsigned).
//  Top level holds vsync edge detect, FSM, active registers and upd.
// TESTING
//  Reset -> bright=0, contr=128, satur=128, dirty=0, upd=0.
//  3x binc, then vsync rise -> dirty=1 until commit, bright=24 the cycle after
//   the edge, upd=1 for exactly 1 cycle.
//  20x cdec, then commit -> contr=32 (clamped). 13x binc -> bright=96.
//   Further binc -> shadow unchanged, dirty stays 0 after commit.
//  binc+bdec same cycle -> no change, dirty=0. sinc+cinc same cycle ->
//   satur=144, contr=136 after commit.
//  binc in the same cycle as vsync rise -> that edit is excluded from the
//   commit, dirty=1 remains, bright +8 at the next vsync rise.
//  def_load with binc, then commit -> defaults. rst low while PEND ->
//   defaults, dirty=0; vsync held high 100 cycles -> single upd.

Source files
------------

// File: rtl/adj_pkg.sv
// Shared constants and types for the brightness/contrast/saturation level controller.
package adj_pkg;

  localparam int unsigned LVL_W  = 8;
  localparam int unsigned CALC_W = 10;

  typedef logic signed [CALC_W-1:0] calc_t;

  localparam calc_t BR_STEP  = calc_t'(8);
  localparam calc_t BR_MIN   = calc_t'(-96);
  localparam calc_t BR_MAX   = calc_t'(96);
  localparam calc_t BR_DEF   = calc_t'(0);

  localparam calc_t CT_STEP  = calc_t'(8);
  localparam calc_t CT_MIN   = calc_t'(32);
  localparam calc_t CT_MAX   = calc_t'(255);
  localparam calc_t CT_DEF   = calc_t'(128);

  localparam calc_t SAT_STEP = calc_t'(16);
  localparam calc_t SAT_MIN  = calc_t'(0);
  localparam calc_t SAT_MAX  = calc_t'(255);
  localparam calc_t SAT_DEF  = calc_t'(128);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

endpackage

// File: rtl/sat_step.sv
// One shadow level channel: saturating inc/dec by a step, default load,
// and a same-cycle flag telling whether the stored value is about to change.
module sat_step
  import adj_pkg::*;
#(
  parameter bit    IS_SIGNED = 1'b0,
  parameter calc_t DFLT      = calc_t'(0)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             load_i,
  input  calc_t            step_i,
  input  calc_t            min_i,
  input  calc_t            max_i,
  output logic [LVL_W-1:0] value_o,
  output logic             changed_c_o
);

  logic [LVL_W-1:0] value_q, value_d;
  calc_t            cur, delta, sum, nxt;

  // Widen to the calculation width so overshoot past a limit is visible before clamping.
  always_comb begin
    cur   = IS_SIGNED ? {{(CALC_W-LVL_W){value_q[LVL_W-1]}}, value_q}
                      : {{(CALC_W-LVL_W){1'b0}}, value_q};
    delta = '0;
    if (inc_i && !dec_i) begin
      delta = step_i;
    end else if (dec_i && !inc_i) begin
      delta = -step_i;
    end
    sum = cur + delta;
    if (load_i) begin
      nxt = DFLT;
    end else if (sum > max_i) begin
      nxt = max_i;
    end else if (sum < min_i) begin
      nxt = min_i;
    end else begin
      nxt = sum;
    end
    value_d     = nxt[LVL_W-1:0];
    changed_c_o = (value_d != value_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= DFLT[LVL_W-1:0];
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/adj_level_ctrl.sv
// Held brightness/contrast/saturation levels: edits go to shadow registers and
// are copied to the active outputs only on a vsync rising edge.
module adj_level_ctrl
  import adj_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             binc_i,
  input  logic             bdec_i,
  input  logic             cinc_i,
  input  logic             cdec_i,
  input  logic             sinc_i,
  input  logic             sdec_i,
  input  logic             def_load_i,
  input  logic             vsync_i,
  output logic [LVL_W-1:0] bright_o,
  output logic [LVL_W-1:0] contr_o,
  output logic [LVL_W-1:0] satur_o,
  output logic             dirty_o,
  output logic             upd_o
);

  logic [LVL_W-1:0] br_sh, ct_sh, sat_sh;
  logic             br_chg_c, ct_chg_c, sat_chg_c;
  logic [LVL_W-1:0] bright_q, contr_q, satur_q;
  logic             vs_q, dirty_q, upd_q;
  state_e           state_q;
  logic             vs_rise_c, any_chg_c, commit_c;

  sat_step #(.IS_SIGNED(1'b1), .DFLT(BR_DEF)) u_br (
    .clk(clk), .rst_n(rst_n), .inc_i(binc_i), .dec_i(bdec_i), .load_i(def_load_i),
    .step_i(BR_STEP), .min_i(BR_MIN), .max_i(BR_MAX),
    .value_o(br_sh), .changed_c_o(br_chg_c)
  );

  sat_step #(.IS_SIGNED(1'b0), .DFLT(CT_DEF)) u_ct (
    .clk(clk), .rst_n(rst_n), .inc_i(cinc_i), .dec_i(cdec_i), .load_i(def_load_i),
    .step_i(CT_STEP), .min_i(CT_MIN), .max_i(CT_MAX),
    .value_o(ct_sh), .changed_c_o(ct_chg_c)
  );

  sat_step #(.IS_SIGNED(1'b0), .DFLT(SAT_DEF)) u_sat (
    .clk(clk), .rst_n(rst_n), .inc_i(sinc_i), .dec_i(sdec_i), .load_i(def_load_i),
    .step_i(SAT_STEP), .min_i(SAT_MIN), .max_i(SAT_MAX),
    .value_o(sat_sh), .changed_c_o(sat_chg_c)
  );

  always_comb begin
    vs_rise_c = vsync_i & ~vs_q;
    any_chg_c = br_chg_c | ct_chg_c | sat_chg_c;
    commit_c  = (state_q == ST_PEND) && vs_rise_c;
  end

  // Commit copies the shadow as it stood before this cycle's edits; an edit
  // landing on the edge keeps the controller pending for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q     <= 1'b0;
      upd_q    <= 1'b0;
      dirty_q  <= 1'b0;
      state_q  <= ST_IDLE;
      bright_q <= BR_DEF[LVL_W-1:0];
      contr_q  <= CT_DEF[LVL_W-1:0];
      satur_q  <= SAT_DEF[LVL_W-1:0];
    end else begin
      vs_q  <= vsync_i;
      upd_q <= commit_c;
      if (commit_c) begin
        bright_q <= br_sh;
        contr_q  <= ct_sh;
        satur_q  <= sat_sh;
      end
      case (state_q)
        ST_IDLE: begin
          if (any_chg_c) begin
            state_q <= ST_PEND;
            dirty_q <= 1'b1;
          end
        end
        ST_PEND: begin
          if (vs_rise_c) begin
            state_q <= any_chg_c ? ST_PEND : ST_IDLE;
            dirty_q <= any_chg_c;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          dirty_q <= 1'b0;
        end
      endcase
    end
  end

  assign bright_o = bright_q;
  assign contr_o  = contr_q;
  assign satur_o  = satur_q;
  assign dirty_o  = dirty_q;
  assign upd_o    = upd_q;

endmodule

// File: tb/tb_adj_level_ctrl.sv
// Directed and randomized bench for adj_level_ctrl against a per-cycle behavioural model.
module tb_adj_level_ctrl;

  logic       clk;
  logic       rst_n;
  logic       binc_i, bdec_i, cinc_i, cdec_i, sinc_i, sdec_i, def_load_i, vsync_i;
  logic [7:0] bright_o, contr_o, satur_o;
  logic       dirty_o, upd_o;

  adj_level_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .binc_i(binc_i), .bdec_i(bdec_i), .cinc_i(cinc_i), .cdec_i(cdec_i),
    .sinc_i(sinc_i), .sdec_i(sdec_i), .def_load_i(def_load_i), .vsync_i(vsync_i),
    .bright_o(bright_o), .contr_o(contr_o), .satur_o(satur_o),
    .dirty_o(dirty_o), .upd_o(upd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel order: 0 brightness, 1 contrast, 2 saturation.
  int lo_a[3] = '{-96, 32, 0};
  int hi_a[3] = '{96, 255, 255};
  int st_a[3] = '{8, 8, 16};
  int df_a[3] = '{0, 128, 128};

  int m_sh[3];
  int m_ac[3];
  bit m_pend, m_upd, m_vs;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sbright();
    logic signed [7:0] b;
    b = bright_o;
    return int'(b);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_sh[k] = df_a[k];
      m_ac[k] = df_a[k];
    end
    m_pend = 1'b0;
    m_upd  = 1'b0;
    m_vs   = 1'b0;
  endtask

  // p = {vsync, def_load, sdec, sinc, cdec, cinc, bdec, binc}
  task automatic model_step(input logic [7:0] p);
    int  nsh[3];
    int  v;
    bit  chg, rise, up, dn;
    chg = 1'b0;
    for (int k = 0; k < 3; k++) begin
      up = p[2*k];
      dn = p[2*k+1];
      if (p[6]) begin
        v = df_a[k];
      end else begin
        v = m_sh[k];
        if (up && !dn) v = v + st_a[k];
        if (dn && !up) v = v - st_a[k];
        if (v > hi_a[k]) v = hi_a[k];
        if (v < lo_a[k]) v = lo_a[k];
      end
      nsh[k] = v;
      if (v != m_sh[k]) chg = 1'b1;
    end
    rise = p[7] && !m_vs;
    m_vs = p[7];
    if (m_pend && rise) begin
      for (int k = 0; k < 3; k++) m_ac[k] = m_sh[k];
      m_upd  = 1'b1;
      m_pend = chg;
    end else begin
      m_upd = 1'b0;
      if (chg) m_pend = 1'b1;
    end
    for (int k = 0; k < 3; k++) m_sh[k] = nsh[k];
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bright"}, sbright(), m_ac[0]);
    chk({tag, ".contr"}, int'(contr_o), m_ac[1]);
    chk({tag, ".satur"}, int'(satur_o), m_ac[2]);
    chk({tag, ".dirty"}, int'(dirty_o), int'(m_pend));
    chk({tag, ".upd"}, int'(upd_o), int'(m_upd));
  endtask

  task automatic apply(input logic [7:0] p, input string tag);
    @(negedge clk);
    {vsync_i, def_load_i, sdec_i, sinc_i, cdec_i, cinc_i, bdec_i, binc_i} = p;
    @(posedge clk);
    #1;
    model_step(p);
    check_all(tag);
  endtask

  task automatic repeat_apply(input logic [7:0] p, input int n, input string tag);
    for (int i = 0; i < n; i++) apply(p, tag);
  endtask

  // Commit sequence: make sure vsync is low, then raise it for one cycle.
  task automatic frame(input string tag);
    apply(8'h00, tag);
    apply(8'h80, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    {vsync_i, def_load_i, sdec_i, sinc_i, cdec_i, cinc_i, bdec_i, binc_i} = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int upd_cnt;
    logic [7:0] p;
    rst_n = 1'b1;
    {vsync_i, def_load_i, sdec_i, sinc_i, cdec_i, cinc_i, bdec_i, binc_i} = 8'h00;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    repeat_apply(8'h01, 3, "binc3");
    chk("binc3.dirty_pend", int'(dirty_o), 1);
    frame("commit24");
    chk("commit24.bright", sbright(), 24);
    chk("commit24.upd", int'(upd_o), 1);
    apply(8'h00, "post24");
    chk("post24.upd", int'(upd_o), 0);

    repeat_apply(8'h08, 20, "cdec20");
    frame("commit_ct");
    chk("commit_ct.contr", int'(contr_o), 32);

    repeat_apply(8'h01, 13, "binc13");
    frame("commit_bmax");
    chk("commit_bmax.bright", sbright(), 96);
    repeat_apply(8'h01, 2, "binc_clamped");
    chk("binc_clamped.dirty", int'(dirty_o), 0);
    frame("noop_frame");
    chk("noop_frame.upd", int'(upd_o), 0);

    apply(8'h03, "binc_bdec");
    chk("binc_bdec.dirty", int'(dirty_o), 0);

    apply(8'h40, "defload");
    frame("commit_def");
    apply(8'h14, "sinc_cinc");
    frame("commit_sc");
    chk("commit_sc.contr", int'(contr_o), 136);
    chk("commit_sc.satur", int'(satur_o), 144);

    apply(8'h01, "pre_edge");
    apply(8'h00, "pre_edge");
    apply(8'h81, "edge_edit");
    chk("edge_edit.bright", sbright(), 8);
    chk("edge_edit.dirty", int'(dirty_o), 1);
    frame("next_frame");
    chk("next_frame.bright", sbright(), 16);

    apply(8'h41, "def_binc");
    frame("commit_def2");
    chk("commit_def2.bright", sbright(), 0);
    chk("commit_def2.contr", int'(contr_o), 128);

    apply(8'h11, "pend_rst");
    do_reset("rst_pend");
    chk("rst_pend.dirty", int'(dirty_o), 0);

    apply(8'h01, "hold_pre");
    apply(8'h00, "hold_pre");
    upd_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      apply(8'h80, "hold");
      if (upd_o === 1'b1) upd_cnt++;
    end
    chk("hold.upd_count", upd_cnt, 1);

    for (int i = 0; i < 600; i++) begin
      p = 8'h00;
      for (int b = 0; b < 6; b++) p[b] = ($urandom_range(0, 3) == 0);
      p[6] = ($urandom_range(0, 31) == 0);
      p[7] = ($urandom_range(0, 5) == 0);
      apply(p, "rand");
      if (i == 300) do_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
